led_panel_scan_ctrl: RTL and testbench
======================================

# led_panel_scan_ctrl

Scan scheduler for the HUB-style RGB LED panel. It requests pixel data for each row from a framebuffer read port through a req/ack handshake, and shifts two half-panel colour streams into the column drivers. It then latches them and unblanks the row for a bit-plane-weighted time (binary code modulation), which gives 2^PLANES brightness levels per colour. It owns the row address clock/reset and sits between the framebuffer and the panel pins.

## Interface
Parameters:
- COLS, 32, columns shifted per row (power of two, max 64)
- PLANES, 4, brightness bit-planes per row (max 4)
- BASE_DELAY, 4, unblanked cycles for plane 0; plane p shows BASE_DELAY<<p cycles

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  run scanning; low = stop after current row completes
- rowmax_in  in  4  index of last row (rows scanned = rowmax_in+1)
- pix_req  out  1  pixel fetch request; held until acked
- pix_row  out  4  row address of request
- pix_col  out  6  column address of request (0..COLS-1)
- pix_plane  out  2  bit-plane of request
- pix_ack  in  1  pixel data valid this cycle
- pix_data  in  6  {r_top,g_top,b_top,r_bot,g_bot,b_bot} for the addressed bit-plane
- sclk_out  out  1  column shift clock; data captured by panel on rising edge
- latch_out  out  1  active-high column latch strobe
- blank_out  out  1  active-high output blank
- aclk_out  out  1  row address advance pulse
- arst_out  out  1  row address reset
- rgb_top_out  out  3  upper-half r,g,b data
- rgb_bot_out  out  3  lower-half r,g,b data
- frame_out  out  1  one-cycle pulse when the row counter wraps to 0

## Operation
- Reset values: sclk_out=1, latch_out=0, blank_out=1, aclk_out=0, arst_out=1, rgb_*=0, pix_req=0, frame_out=0. Internal counters: row=0, plane=0, col=0. State=IDLE.
- IDLE: blank high, arst_out held from reset until first exit. When enable=1: arst_out<=0, go to FETCH.
- FETCH: pix_req=1. Address = {row,col,plane} is stable while req is high. On the cycle pix_ack=1 (any cycle req is high, including the first), capture pix_data, drop req, go to SHIFT_LO. pix_ack while req=0 is ignored.
- SHIFT_LO: sclk_out<=0; rgb outputs <= captured data.
- SHIFT_HI: sclk_out<=1 (panel captures); col<=col+1. If col was COLS-1, col<=0 and go to LATCH; else go to FETCH.
- LATCH: latch_out=1 for exactly one cycle; blank stays high.
- SHOW: blank_out=0 for BASE_DELAY<<plane cycles, then blank_out<=1.
  - If plane<PLANES-1: plane++ and go to FETCH.
  - Else: plane<=0 and go to NEXT.
- NEXT (one cycle):
  - If row>=rowmax_in: row<=0, arst_out pulses 1 for one cycle, frame_out pulses.
  - Else: row++, aclk_out pulses 1 for one cycle.
  - Then go to FETCH if enable=1, else IDLE.
- enable is only sampled in IDLE and NEXT; deasserting mid-row completes all planes of the current row.
- rowmax_in is sampled only in NEXT. The >= compare makes lowering rowmax_in mid-frame wrap at the next NEXT.
- Async reset mid-operation forces reset values immediately. An abandoned pix_req simply drops; the source must tolerate this.

## Timing
- Per column: FETCH (≥1 cycle, 1 with zero-wait ack) + SHIFT_LO + SHIFT_HI = minimum 3 cycles.
- Per plane: 3*COLS + 1 (LATCH) + BASE_DELAY<<p cycles with zero-wait ack. Default plane 0 takes 101 cycles.
- Per row (defaults, zero-wait): 4*97 + 4*(1+2+4+8) + 1 = 449 cycles.
- rgb outputs change only on the falling sclk edge (SHIFT_LO) and are stable across the rising edge.
- aclk_out and arst_out are never high together. Both occur only while blank_out=1.

## Structure
- Shared package led_panel_pkg:
  - state enum (IDLE, FETCH, SHIFT_LO, SHIFT_HI, LATCH, SHOW, NEXT)
  - pix_data field index constants
  - default COLS/PLANES/BASE_DELAY
- Sub-module led_panel_bcm_timer: down-counter loaded with BASE_DELAY<<plane on SHOW entry, asserts done on its last cycle. It is reused by future panel variants.

## Test plan
- Reset asserted mid-SHIFT_HI: all outputs return to reset values the same cycle; after release with enable=1, the first pix_req addresses row 0, col 0, plane 0.
- Zero-wait ack, pix_data=6'b101010: exactly 32 sclk rising edges per plane, with rgb_top=101 and rgb_bot=010 at each edge; then one latch pulse, and blank low for 4/8/16/32 cycles on planes 0–3.
- Ack delayed 5 cycles on col 7: pix_row, pix_col and pix_plane are held constant for all 6 req cycles; sclk stays high; the next shift is unchanged.
- rowmax_in=3, zero-wait: aclk pulses after rows 0,1,2; arst and frame pulse after row 3; row period = 449 cycles.
- Deassert enable during plane 1 of row 2: row 2 finishes all 4 planes, aclk pulses, then IDLE with blank=1 and no further pix_req.
- Change rowmax_in from 7 to 1 while row=5: the next NEXT wraps to row 0 with an arst pulse.

Source files
------------

// File: rtl/led_panel_scan_ctrl_pkg.sv
// rtl/led_panel_scan_ctrl_pkg.sv - shared states, pixel field indices and defaults
// for the LED panel scan controller.
package led_panel_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SHIFT_LO,
    SHIFT_HI,
    LATCH,
    SHOW,
    NEXT
  } state_t;

  // pix_data = {r_top, g_top, b_top, r_bot, g_bot, b_bot}
  localparam int PIX_R_TOP = 5;
  localparam int PIX_G_TOP = 4;
  localparam int PIX_B_TOP = 3;
  localparam int PIX_R_BOT = 2;
  localparam int PIX_G_BOT = 1;
  localparam int PIX_B_BOT = 0;

  localparam int DEF_COLS       = 32;
  localparam int DEF_PLANES     = 4;
  localparam int DEF_BASE_DELAY = 4;
  localparam int BCM_CNT_W      = 16;

  function automatic int bcm_cycles(input int base, input int plane);
    return base << plane;
  endfunction

endpackage

// File: rtl/led_panel_scan_ctrl_if.sv
// rtl/led_panel_scan_ctrl_if.sv - framebuffer pixel fetch port (req/ack handshake).
interface led_panel_scan_ctrl_if;

  logic       pix_req;
  logic [3:0] pix_row;
  logic [5:0] pix_col;
  logic [1:0] pix_plane;
  logic       pix_ack;
  logic [5:0] pix_data;

  modport master (
    output pix_req, pix_row, pix_col, pix_plane,
    input  pix_ack, pix_data
  );

  modport slave (
    input  pix_req, pix_row, pix_col, pix_plane,
    output pix_ack, pix_data
  );

endinterface

// File: rtl/led_panel_scan_ctrl_bcm_timer.sv
// rtl/led_panel_scan_ctrl_bcm_timer.sv - bit-plane weighted on-time counter;
// o_done marks the last cycle of a BASE_DELAY<<plane window started by i_load.
module led_panel_bcm_timer
  import led_panel_pkg::*;
#(
  parameter int BASE_DELAY = DEF_BASE_DELAY,
  parameter int CNT_W      = BCM_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic [1:0] i_plane,
  output logic       o_done
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_load_val;

  assign w_load_val = CNT_W'(bcm_cycles(BASE_DELAY, int'(i_plane)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= w_load_val - CNT_W'(1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/led_panel_scan_ctrl.sv
// rtl/led_panel_scan_ctrl.sv - HUB RGB panel scan scheduler: fetches pixels per
// row/plane, shifts both half-panel streams, latches and shows each plane with BCM timing.
module led_panel_scan_ctrl
  import led_panel_pkg::*;
#(
  parameter int COLS       = DEF_COLS,
  parameter int PLANES     = DEF_PLANES,
  parameter int BASE_DELAY = DEF_BASE_DELAY
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [3:0]                    rowmax_in,
  led_panel_scan_ctrl_if.master         pix,
  output logic                          sclk_out,
  output logic                          latch_out,
  output logic                          blank_out,
  output logic                          aclk_out,
  output logic                          arst_out,
  output logic [2:0]                    rgb_top_out,
  output logic [2:0]                    rgb_bot_out,
  output logic                          frame_out
);

  localparam logic [5:0] COL_LAST   = 6'(COLS - 1);
  localparam logic [1:0] PLANE_LAST = 2'(PLANES - 1);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_row;
  logic [5:0] r_col;
  logic [1:0] r_plane;
  logic       r_arst_hold;
  logic [2:0] r_rgb_top;
  logic [2:0] r_rgb_bot;
  logic       w_ack;
  logic       w_wrap;
  logic       w_show_done;
  logic       w_bcm_load;

  assign w_ack      = (r_state == FETCH) && pix.pix_ack;
  assign w_wrap     = (r_row >= rowmax_in);
  assign w_bcm_load = (r_state == LATCH);

  led_panel_bcm_timer #(
    .BASE_DELAY (BASE_DELAY),
    .CNT_W      (BCM_CNT_W)
  ) u_bcm_timer (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_bcm_load),
    .i_plane (r_plane),
    .o_done  (w_show_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    pix.pix_req = 1'b0;
    sclk_out    = 1'b1;
    latch_out   = 1'b0;
    blank_out   = 1'b1;
    aclk_out    = 1'b0;
    arst_out    = r_arst_hold;
    frame_out   = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable) w_next = FETCH;
      end
      FETCH: begin
        pix.pix_req = 1'b1;
        if (pix.pix_ack) w_next = SHIFT_LO;
      end
      SHIFT_LO: begin
        sclk_out = 1'b0;
        w_next   = SHIFT_HI;
      end
      SHIFT_HI: begin
        w_next = (r_col == COL_LAST) ? LATCH : FETCH;
      end
      LATCH: begin
        latch_out = 1'b1;
        w_next    = SHOW;
      end
      SHOW: begin
        blank_out = 1'b0;
        if (w_show_done) w_next = (r_plane == PLANE_LAST) ? NEXT : FETCH;
      end
      NEXT: begin
        aclk_out  = ~w_wrap;
        arst_out  = w_wrap;
        frame_out = w_wrap;
        w_next    = enable ? FETCH : IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // rgb is loaded on the ack edge, i.e. the same edge that drops sclk, so it
  // only ever changes on the falling shift clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row       <= '0;
      r_col       <= '0;
      r_plane     <= '0;
      r_arst_hold <= 1'b1;
      r_rgb_top   <= '0;
      r_rgb_bot   <= '0;
    end else begin
      if ((r_state == IDLE) && enable) begin
        r_arst_hold <= 1'b0;
      end
      if (w_ack) begin
        r_rgb_top <= pix.pix_data[PIX_R_TOP -: 3];
        r_rgb_bot <= pix.pix_data[PIX_R_BOT -: 3];
      end
      if (r_state == SHIFT_HI) begin
        r_col <= (r_col == COL_LAST) ? 6'd0 : r_col + 6'd1;
      end
      if ((r_state == SHOW) && w_show_done) begin
        r_plane <= (r_plane == PLANE_LAST) ? 2'd0 : r_plane + 2'd1;
      end
      if (r_state == NEXT) begin
        r_row <= w_wrap ? 4'd0 : r_row + 4'd1;
      end
    end
  end

  assign pix.pix_row   = r_row;
  assign pix.pix_col   = r_col;
  assign pix.pix_plane = r_plane;
  assign rgb_top_out   = r_rgb_top;
  assign rgb_bot_out   = r_rgb_bot;

endmodule

// File: tb/tb_led_panel_scan_ctrl.sv
// tb/tb_led_panel_scan_ctrl.sv - randomized self-checking bench for led_panel_scan_ctrl
// against an event-stream reference model of the scan order.
module tb_led_panel_scan_ctrl;
  import led_panel_pkg::*;

  localparam int COLS       = 32;
  localparam int PLANES     = 4;
  localparam int BASE_DELAY = 4;
  localparam int ROW_CYCLES = PLANES * (3 * COLS + 1) + BASE_DELAY * 15 + 1;

  localparam int SYM_SHIFT  = 1000;
  localparam int SYM_LATCH  = 2000;
  localparam int SYM_BLANK  = 3000;
  localparam int SYM_ACLK   = 4000;
  localparam int SYM_WRAP   = 5000;
  localparam int SYM_ARSTNF = 6000;
  localparam int SYM_FRAMEO = 7000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] rowmax_in = 4'd0;
  logic       sclk_out, latch_out, blank_out, aclk_out, arst_out, frame_out;
  logic [2:0] rgb_top_out, rgb_bot_out;

  led_panel_scan_ctrl_if bif ();

  led_panel_scan_ctrl #(
    .COLS       (COLS),
    .PLANES     (PLANES),
    .BASE_DELAY (BASE_DELAY)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .rowmax_in   (rowmax_in),
    .pix         (bif),
    .sclk_out    (sclk_out),
    .latch_out   (latch_out),
    .blank_out   (blank_out),
    .aclk_out    (aclk_out),
    .arst_out    (arst_out),
    .rgb_top_out (rgb_top_out),
    .rgb_bot_out (rgb_bot_out),
    .frame_out   (frame_out)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  bit   last_ok;
  logic [5:0] mem [16][64][4];
  bit   delay_mode = 0;
  bit   spurious = 0;
  bit   long_col7 = 0;

  int         q_sym[$];
  logic [5:0] q_shift[$];
  int         q_addr[$];
  int         q_reqlen[$];
  int         q_ev_cyc[$];
  int         mon_err = 0;
  int         cyc = 0;

  int         exp_sym[$];
  logic [5:0] exp_shift[$];
  int         exp_addr[$];

  // Observation of the panel pins and fetch port, reduced to an ordered event stream.
  logic       p_sclk = 1'b1, p_blank = 1'b1, p_arst = 1'b1, p_req = 1'b0;
  logic [5:0] p_rgb = '0;
  int         p_addr = 0, m_addr = 0, blank_run = 0, req_len = 0;

  always @(negedge clk) begin
    cyc++;
    m_addr = {bif.pix_row, bif.pix_col, bif.pix_plane};
    if (reset) begin
      q_sym.delete(); q_shift.delete(); q_addr.delete(); q_reqlen.delete(); q_ev_cyc.delete();
      mon_err = 0; blank_run = 0; req_len = 0;
    end else begin
      if (!p_sclk && sclk_out) begin
        q_sym.push_back(SYM_SHIFT);
        q_shift.push_back({rgb_top_out, rgb_bot_out});
      end
      if (p_sclk && sclk_out && ({rgb_top_out, rgb_bot_out} != p_rgb)) mon_err++;
      if (bif.pix_req && !sclk_out) mon_err++;
      if (bif.pix_req && !p_req) q_addr.push_back(m_addr);
      if (bif.pix_req && p_req && (m_addr != p_addr)) mon_err++;
      if (bif.pix_req) req_len++;
      else if (p_req) begin q_reqlen.push_back(req_len); req_len = 0; end
      if (latch_out) begin
        q_sym.push_back(SYM_LATCH);
        if (!blank_out) mon_err++;
      end
      if (!blank_out) blank_run++;
      else if (!p_blank) begin q_sym.push_back(SYM_BLANK + blank_run); blank_run = 0; end
      if (aclk_out) begin q_sym.push_back(SYM_ACLK); q_ev_cyc.push_back(cyc); end
      if (arst_out && !p_arst) begin
        q_sym.push_back(frame_out ? SYM_WRAP : SYM_ARSTNF);
        q_ev_cyc.push_back(cyc);
      end
      if (frame_out && !arst_out) q_sym.push_back(SYM_FRAMEO);
      if (aclk_out && arst_out) mon_err++;
      if ((aclk_out || arst_out) && !blank_out) mon_err++;
    end
    p_sclk  = sclk_out;
    p_blank = blank_out;
    p_arst  = arst_out;
    p_req   = bif.pix_req;
    p_rgb   = {rgb_top_out, rgb_bot_out};
    p_addr  = m_addr;
  end

  // Framebuffer model: answers each request after a chosen number of wait cycles.
  initial begin
    int req_cnt;
    int tgt;
    req_cnt = 0;
    tgt = 0;
    bif.pix_ack  = 1'b0;
    bif.pix_data = '0;
    forever begin
      @(negedge clk);
      if (bif.pix_req && !reset) begin
        if (req_cnt == 0) begin
          if (long_col7 && bif.pix_row == 4'd0 && bif.pix_col == 6'd7 && bif.pix_plane == 2'd0) tgt = 5;
          else if (delay_mode) tgt = int'($urandom_range(0, 3));
          else tgt = 0;
        end
        bif.pix_ack  = (req_cnt == tgt);
        bif.pix_data = (req_cnt == tgt) ? mem[bif.pix_row][bif.pix_col][bif.pix_plane] : 6'($urandom);
        req_cnt++;
      end else begin
        req_cnt = 0;
        bif.pix_ack  = spurious && ($urandom_range(0, 3) == 0);
        bif.pix_data = 6'($urandom);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    last_ok = 1'b1;
    assert (obs === expv) else begin
      n_err++;
      last_ok = 1'b0;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_outs"},
        32'({sclk_out, latch_out, blank_out, aclk_out, arst_out, rgb_top_out, rgb_bot_out, bif.pix_req, frame_out}),
        32'({1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0}));
    chk({tag, "_addr"}, 32'({bif.pix_row, bif.pix_col, bif.pix_plane}), 32'd0);
  endtask

  task automatic wait_ev(input string tag, input int n, input int limit);
    int k;
    k = 0;
    while (q_ev_cyc.size() < n && k < limit) begin tick(); k++; end
    chk({tag, "_rows_done"}, 32'(q_ev_cyc.size() >= n), 32'd1);
  endtask

  function automatic int blank_count();
    int n;
    n = 0;
    foreach (q_sym[i]) if (q_sym[i] > SYM_BLANK && q_sym[i] < SYM_ACLK) n++;
    return n;
  endfunction

  // Reference scan order: rows, then planes, then columns; rowmax may change after n_first rows.
  task automatic build_expect(input int nrows, input int rm_first, input int n_first, input int rm_rest);
    int row;
    row = 0;
    exp_sym.delete(); exp_shift.delete(); exp_addr.delete();
    for (int k = 0; k < nrows; k++) begin
      int rm;
      rm = (k < n_first) ? rm_first : rm_rest;
      for (int p = 0; p < PLANES; p++) begin
        for (int c = 0; c < COLS; c++) begin
          exp_sym.push_back(SYM_SHIFT);
          exp_shift.push_back(mem[row][c][p]);
          exp_addr.push_back(row * 256 + c * 4 + p);
        end
        exp_sym.push_back(SYM_LATCH);
        exp_sym.push_back(SYM_BLANK + (BASE_DELAY << p));
      end
      if (row >= rm) begin exp_sym.push_back(SYM_WRAP); row = 0; end
      else begin exp_sym.push_back(SYM_ACLK); row++; end
    end
  endtask

  task automatic cmp_streams(input string tag);
    chk({tag, "_sym_len"}, 32'((q_sym.size() < exp_sym.size()) ? q_sym.size() : exp_sym.size()), 32'(exp_sym.size()));
    for (int i = 0; i < exp_sym.size() && i < q_sym.size(); i++) begin
      chk($sformatf("%s_sym[%0d]", tag, i), 32'(q_sym[i]), 32'(exp_sym[i]));
      if (!last_ok) break;
    end
    for (int i = 0; i < exp_shift.size() && i < q_shift.size(); i++) begin
      chk($sformatf("%s_rgb[%0d]", tag, i), 32'(q_shift[i]), 32'(exp_shift[i]));
      if (!last_ok) break;
    end
    for (int i = 0; i < exp_addr.size() && i < q_addr.size(); i++) begin
      chk($sformatf("%s_addr[%0d]", tag, i), 32'(q_addr[i]), 32'(exp_addr[i]));
      if (!last_ok) break;
    end
    chk({tag, "_monitor"}, 32'(mon_err), 32'd0);
  endtask

  initial begin
    int k;
    int rm_r;

    // Reset state
    foreach (mem[r, c, p]) mem[r][c][p] = 6'b101010;
    rowmax_in = 4'd3;
    repeat (3) tick();
    check_reset("reset_vals");

    // Fixed pattern, zero-wait ack, four-row frame
    enable = 1'b1;
    #2 reset = 1'b0;
    wait_ev("pattern", 4, 2500);
    build_expect(4, 3, 4, 3);
    cmp_streams("pattern");
    for (int i = 1; i < 4 && i < q_ev_cyc.size(); i++)
      chk($sformatf("row_period[%0d]", i), 32'(q_ev_cyc[i] - q_ev_cyc[i-1]), 32'(ROW_CYCLES));

    // Async reset asserted in the middle of SHIFT_HI
    k = 0;
    while (sclk_out !== 1'b0 && k < 200) begin tick(); k++; end
    chk("found_shift_lo", 32'(sclk_out), 32'd0);
    @(negedge clk);
    chk("in_shift_hi", 32'(sclk_out), 32'd1);
    #2 reset = 1'b1;
    #1 check_reset("reset_mid_shift");
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    k = 0;
    while (q_addr.size() < 1 && k < 20) begin tick(); k++; end
    chk("first_req_addr", (q_addr.size() > 0) ? 32'(q_addr[0]) : 32'hFFFF, 32'd0);

    // Random pixels, random ack latency, spurious acks, long wait on col 7
    foreach (mem[r, c, p]) mem[r][c][p] = 6'($urandom);
    delay_mode = 1'b1;
    spurious   = 1'b1;
    long_col7  = 1'b1;
    rm_r       = int'($urandom_range(1, 2));
    rowmax_in  = 4'(rm_r);
    apply_reset();
    wait_ev("random", 3, 5000);
    build_expect(3, rm_r, 3, rm_r);
    cmp_streams("random");
    chk("long_wait_req_cycles", (q_reqlen.size() > 7) ? 32'(q_reqlen[7]) : 32'hFFFF, 32'd6);

    // Enable dropped during plane 1 of row 2
    delay_mode = 1'b0;
    long_col7  = 1'b0;
    rowmax_in  = 4'd7;
    apply_reset();
    k = 0;
    while (blank_count() < 2 * PLANES + 1 && k < 2000) begin tick(); k++; end
    chk("reached_row2_plane1", 32'(blank_count()), 32'(2 * PLANES + 1));
    enable = 1'b0;
    repeat (1200) tick();
    build_expect(3, 7, 3, 7);
    cmp_streams("stop");
    chk("stop_sym_count", 32'(q_sym.size()), 32'(exp_sym.size()));
    chk("stop_req_count", 32'(q_addr.size()), 32'(3 * PLANES * COLS));
    chk("stop_idle_pins", 32'({bif.pix_req, blank_out}), 32'({1'b0, 1'b1}));

    // rowmax lowered from 7 to 1 while scanning row 5
    enable    = 1'b1;
    rowmax_in = 4'd7;
    apply_reset();
    wait_ev("rowmax_a", 5, 3000);
    tick();
    rowmax_in = 4'd1;
    wait_ev("rowmax_b", 8, 2000);
    build_expect(8, 7, 5, 1);
    cmp_streams("rowmax");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
